// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: stage-tracker/PC controls, ROM read channel, fetched word and status.
// master drives requests and ROM responses; slave is the fetch unit itself.
interface instruction_fetch_unit_if;
    logic        IR_Enable;
    logic        PC_Enable;
    logic        PC_Select;
    logic        INC_Select;
    logic [31:0] BranchOffset;
    logic [31:0] RA_In;
    logic [31:0] ROM_Data;
    logic        ROM_Valid;
    logic        ROM_Read;
    logic [31:0] ROM_Address;
    logic [31:0] Instruction;
    logic [31:0] PC_Out;
    logic [31:0] Return_Address;
    logic        Fetch_Busy;
    logic        Fetch_Done;
    logic        Fetch_Error;

    modport master (
        output IR_Enable, PC_Enable, PC_Select, INC_Select, BranchOffset, RA_In,
        output ROM_Data, ROM_Valid,
        input  ROM_Read, ROM_Address, Instruction, PC_Out, Return_Address,
        input  Fetch_Busy, Fetch_Done, Fetch_Error
    );

    modport slave (
        input  IR_Enable, PC_Enable, PC_Select, INC_Select, BranchOffset, RA_In,
        input  ROM_Data, ROM_Valid,
        output ROM_Read, ROM_Address, Instruction, PC_Out, Return_Address,
        output Fetch_Busy, Fetch_Done, Fetch_Error
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register plus IDLE/READ/DONE/ERROR ROM fetch FSM, 15-cycle ROM timeout.
// Latency: IR_Enable -> READ next edge, DONE one edge after ROM_Valid; ROM stalls simply extend READ.
module instruction_fetch_unit (
    input  logic                      Clock,
    input  logic                      Reset,
    instruction_fetch_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, READ, DONE, ERROR} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        pend_vld;
    logic [31:0] next_pc;
    logic [3:0]  wait_cnt;
    logic [31:0] instr_q;
    logic [31:0] ret_q;
    logic [31:0] rom_addr_q;
    logic        rom_read;
    logic        busy;
    logic        done;
    logic        error;

    always_comb begin
        next_pc = bus.PC_Select ? (pc + (bus.INC_Select ? bus.BranchOffset : 32'd1))
                                : bus.RA_In;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rom_read  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.IR_Enable) state_nxt = READ;
            end
            READ: begin
                rom_read = 1'b1;
                busy     = 1'b1;
                // Data arriving on the last allowed cycle still completes the fetch.
                if (bus.ROM_Valid)            state_nxt = DONE;
                else if (wait_cnt == 4'd14)   state_nxt = ERROR;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc         <= 32'd0;
            pend_pc    <= 32'd0;
            pend_vld   <= 1'b0;
            wait_cnt   <= 4'd0;
            instr_q    <= 32'd0;
            ret_q      <= 32'd0;
            rom_addr_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Fetch uses the PC as it stands before this edge's update.
                    if (bus.IR_Enable) begin
                        rom_addr_q <= pc;
                        wait_cnt   <= 4'd0;
                    end
                    if (pend_vld) begin
                        pc       <= pend_pc;
                        pend_vld <= 1'b0;
                    end else if (bus.PC_Enable) begin
                        pc <= next_pc;
                    end
                end
                READ, DONE: begin
                    if (bus.PC_Enable && !pend_vld) begin
                        pend_pc  <= next_pc;
                        pend_vld <= 1'b1;
                    end
                    if (state == READ) begin
                        if (bus.ROM_Valid) begin
                            instr_q <= bus.ROM_Data;
                            ret_q   <= rom_addr_q + 32'd1;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                            if (wait_cnt == 4'd14) instr_q <= 32'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ROM_Read       = rom_read;
    assign bus.ROM_Address    = rom_addr_q;
    assign bus.Instruction    = instr_q;
    assign bus.PC_Out         = pc;
    assign bus.Return_Address = ret_q;
    assign bus.Fetch_Busy     = busy;
    assign bus.Fetch_Done     = done;
    assign bus.Fetch_Error    = error;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; fetched words are scoreboarded through a queue.
module tb_instruction_fetch_unit;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] ret;
    } exp_t;
    exp_t exp_q[$];

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        int   n = 0;
        exp_t e;
        while (bus.Fetch_Done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("done_seen", {31'd0, bus.Fetch_Done}, 32'd1);
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            check("instr", bus.Instruction, e.instr);
            check("ret_addr", bus.Return_Address, e.ret);
        end
        check("busy_done", {31'd0, bus.Fetch_Busy}, 32'd1);
        step();
        check("done_pulse", {31'd0, bus.Fetch_Done}, 32'd0);
        check("busy_idle", {31'd0, bus.Fetch_Busy}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] data, input int delay, input logic [31:0] fpc);
        exp_q.push_back('{instr: data, ret: fpc + 32'd1});
        bus.IR_Enable = 1'b1;
        step();
        bus.IR_Enable = 1'b0;
        bus.PC_Enable = 1'b0;
        check("rom_read", {31'd0, bus.ROM_Read}, 32'd1);
        check("rom_addr", bus.ROM_Address, fpc);
        repeat (delay) step();
        bus.ROM_Valid = 1'b1;
        bus.ROM_Data  = data;
        step();
        bus.ROM_Valid = 1'b0;
        wait_done();
    endtask

    task automatic load_pc(input logic [31:0] target);
        bus.PC_Enable = 1'b1;
        bus.PC_Select = 1'b0;
        bus.RA_In     = target;
        step();
        bus.PC_Enable = 1'b0;
    endtask

    initial begin
        int n;
        bus.IR_Enable    = 1'b0;
        bus.PC_Enable    = 1'b0;
        bus.PC_Select    = 1'b0;
        bus.INC_Select   = 1'b0;
        bus.BranchOffset = 32'd0;
        bus.RA_In        = 32'd0;
        bus.ROM_Data     = 32'd0;
        bus.ROM_Valid    = 1'b0;
        step();
        step();
        Reset = 1'b0;

        check("rst_pc", bus.PC_Out, 32'd0);
        check("rst_instr", bus.Instruction, 32'd0);
        check("rst_ret", bus.Return_Address, 32'd0);
        check("rst_rom_addr", bus.ROM_Address, 32'd0);
        check("rst_flags", {28'd0, bus.ROM_Read, bus.Fetch_Busy, bus.Fetch_Done, bus.Fetch_Error}, 32'd0);

        // Basic fetch, data two cycles after the request
        fetch(32'hDEADBEEF, 1, 32'd0);

        // Branch and jump
        load_pc(32'd10);
        check("pc_jump10", bus.PC_Out, 32'd10);
        bus.PC_Enable    = 1'b1;
        bus.PC_Select    = 1'b1;
        bus.INC_Select   = 1'b1;
        bus.BranchOffset = 32'hFFFFFFFE;
        step();
        check("pc_branch_neg", bus.PC_Out, 32'd8);
        bus.PC_Select = 1'b0;
        bus.RA_In     = 32'h40;
        step();
        check("pc_jump40", bus.PC_Out, 32'h40);
        bus.PC_Select  = 1'b1;
        bus.INC_Select = 1'b0;
        step();
        bus.PC_Enable = 1'b0;
        check("pc_inc", bus.PC_Out, 32'h41);

        // PC update and fetch on the same IDLE edge: fetch uses the old PC
        bus.PC_Enable  = 1'b1;
        bus.PC_Select  = 1'b1;
        bus.INC_Select = 1'b0;
        fetch(32'h12345678, 0, 32'h41);
        check("pc_same_cycle", bus.PC_Out, 32'h42);

        // Data on the 15th READ cycle beats the timeout
        fetch(32'h0BADF00D, 14, 32'h42);
        check("no_err_boundary", {31'd0, bus.Fetch_Error}, 32'd0);

        // PC_Enable during READ is held pending; a second one is dropped
        load_pc(32'd5);
        check("pc5", bus.PC_Out, 32'd5);
        exp_q.push_back('{instr: 32'hA5A50001, ret: 32'd6});
        bus.IR_Enable = 1'b1;
        step();
        bus.IR_Enable  = 1'b0;
        bus.PC_Enable  = 1'b1;
        bus.PC_Select  = 1'b1;
        bus.INC_Select = 1'b0;
        step();
        bus.PC_Select = 1'b0;
        bus.RA_In     = 32'h99;
        step();
        bus.PC_Enable = 1'b0;
        check("mid_rom_addr", bus.ROM_Address, 32'd5);
        check("mid_pc_held", bus.PC_Out, 32'd5);
        bus.ROM_Valid = 1'b1;
        bus.ROM_Data  = 32'hA5A50001;
        step();
        bus.ROM_Valid = 1'b0;
        wait_done();
        check("pend_not_yet", bus.PC_Out, 32'd5);
        bus.PC_Enable = 1'b1;
        bus.PC_Select = 1'b0;
        bus.RA_In     = 32'h77;
        step();
        bus.PC_Enable = 1'b0;
        check("pend_applied", bus.PC_Out, 32'd6);
        step();
        check("pend_stable", bus.PC_Out, 32'd6);

        // 32-bit wrap
        load_pc(32'hFFFFFFFF);
        bus.PC_Enable  = 1'b1;
        bus.PC_Select  = 1'b1;
        bus.INC_Select = 1'b0;
        step();
        bus.PC_Enable = 1'b0;
        check("pc_wrap", bus.PC_Out, 32'd0);

        // Timeout into sticky ERROR
        bus.IR_Enable = 1'b1;
        step();
        bus.IR_Enable = 1'b0;
        n = 0;
        while (bus.ROM_Read === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("read_cycles", n, 32'd15);
        check("err_flag", {31'd0, bus.Fetch_Error}, 32'd1);
        check("err_nop", bus.Instruction, 32'd0);
        check("err_busy", {31'd0, bus.Fetch_Busy}, 32'd0);
        bus.IR_Enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("err_sticky", {30'd0, bus.Fetch_Error, bus.ROM_Read}, 32'd2);
        end
        bus.IR_Enable = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("err_cleared", {31'd0, bus.Fetch_Error}, 32'd0);

        // Reset during READ discards the arriving data
        fetch(32'hFEEDFACE, 0, 32'd0);
        bus.IR_Enable = 1'b1;
        step();
        bus.IR_Enable = 1'b0;
        bus.ROM_Valid = 1'b1;
        bus.ROM_Data  = 32'hCAFEF00D;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        bus.ROM_Valid = 1'b0;
        check("rstr_instr", bus.Instruction, 32'd0);
        check("rstr_ret", bus.Return_Address, 32'd0);
        check("rstr_flags", {29'd0, bus.ROM_Read, bus.Fetch_Busy, bus.Fetch_Done}, 32'd0);
        step();
        check("rstr_idle", {29'd0, bus.ROM_Read, bus.Fetch_Busy, bus.Fetch_Done}, 32'd0);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
